// File: rtl/wm_codec_i2c_init.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wm_codec_i2c_init
//
// Power-up configuration master for a WM8731-class audio codec. Once reset
// is released it writes a fixed table of 16-bit control words to the codec
// over a write-only I2C bus, then raises `done`. Downstream audio blocks
// hold off streaming until `done` is high.
//
// Each word goes out as one frame: START, device address byte, word[15:8],
// word[7:0] (each byte followed by an acknowledge slot), STOP, then a
// 4-quarter bus-free gap. All bus activity moves on a quarter-period tick
// of the SCL clock (QDIV = CLK_FREQ / (4 * I2C_FREQ) system clocks).
//
// Ports:
//   clk   - system clock, all logic on its rising edge
//   reset - asynchronous, active-low reset
//   scl   - I2C clock, push-pull, idles high
//   sda   - I2C data, open-drain (drives 0 or releases to 'z')
//   done  - high once the whole table has been written
//
// Build option:
//   I2C_NACK_RETRY_EN - when defined, a NACK ends the current frame and the
//   same word is resent, up to 3 retries before the word is skipped. When
//   undefined, the acknowledge slot is clocked but its value is not used.
// -----------------------------------------------------------------------------
module wm_codec_i2c_init #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         I2C_FREQ = 100_000,
    parameter logic [7:0] DEV_ADDR = 8'h34,
    parameter int         NUM_REGS = 10
) (
    input  logic clk,
    input  logic reset,
    output logic scl,
    inout  wire  sda,
    output logic done
);

    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int DW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int IW   = $clog2(NUM_REGS + 1);

    // Encoding is fixed: benches probe `state` hierarchically.
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        START       = 4'd1,
        LOAD        = 4'd2,
        TX_BIT      = 4'd3,
        ACK_RELEASE = 4'd4,
        ACK_SAMPLE  = 4'd5,
        STOP        = 4'd6,
        NEXT        = 4'd7,
        DONE        = 4'd8
    } state_t;

    state_t        state;
    logic [DW-1:0] div_reg;
    logic          tick;
    logic [1:0]    qcnt_reg;      // quarter counter inside multi-tick states
    logic [IW-1:0] word_idx_reg;
    logic [1:0]    byte_idx_reg;  // 0: device address, 1: word high, 2: word low
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          scl_reg;
    logic          sda_low_reg;   // 1 pulls sda low, 0 releases it
    logic          done_reg;

    logic [15:0]   cur_word;
    logic [7:0]    byte_next;
    logic          last_word;
    logic          frame_end;
    logic          resend;

`ifdef I2C_NACK_RETRY_EN
    logic          nack_reg;
    logic [1:0]    retry_reg;
`endif

    // Configuration table: {7-bit register address, 9-bit data}.
    function automatic logic [15:0] cfg_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 16'h1E00;  // reset codec
            8'd1:    return 16'h0017;  // left line in
            8'd2:    return 16'h0217;  // right line in
            8'd3:    return 16'h0479;  // left headphone
            8'd4:    return 16'h0679;  // right headphone
            8'd5:    return 16'h0812;  // DAC select
            8'd6:    return 16'h0A00;
            8'd7:    return 16'h0C00;  // power on
            8'd8:    return 16'h0E42;  // master, I2S 16-bit
            8'd9:    return 16'h1201;  // active
            default: return 16'h0000;
        endcase
    endfunction

    assign tick = (div_reg == DW'(QDIV - 1));

    always_comb begin
        cur_word = cfg_word(8'(word_idx_reg));
        case (byte_idx_reg)
            2'd0:    byte_next = DEV_ADDR;
            2'd1:    byte_next = cur_word[15:8];
            default: byte_next = cur_word[7:0];
        endcase
    end

    assign last_word = ((word_idx_reg + IW'(1)) == IW'(NUM_REGS));

`ifdef I2C_NACK_RETRY_EN
    // A NACK cuts the frame short; the word is repeated until it has been
    // retried three times, after which it is skipped.
    assign frame_end = (byte_idx_reg == 2'd2) || nack_reg;
    assign resend    = nack_reg && (retry_reg != 2'd3);
`else
    assign frame_end = (byte_idx_reg == 2'd2);
    assign resend    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            div_reg      <= '0;
            qcnt_reg     <= '0;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            scl_reg      <= 1'b1;
            sda_low_reg  <= 1'b0;
            done_reg     <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            nack_reg     <= 1'b0;
            retry_reg    <= '0;
`endif
        end else begin
            div_reg <= tick ? '0 : div_reg + DW'(1);

            if (tick) begin
                // Quarter counter free-runs; states shorter than 4 quarters
                // clear it explicitly on exit.
                qcnt_reg <= qcnt_reg + 2'd1;

                case (state)
                    IDLE: begin
                        scl_reg     <= 1'b1;
                        sda_low_reg <= 1'b0;
                        if (qcnt_reg == 2'd3) begin
                            state <= START;
                        end
                    end

                    START: begin
                        if (qcnt_reg == 2'd0) begin
                            // sda falls while scl is still high
                            scl_reg      <= 1'b1;
                            sda_low_reg  <= 1'b1;
                            byte_idx_reg <= 2'd0;
`ifdef I2C_NACK_RETRY_EN
                            nack_reg     <= 1'b0;
`endif
                        end else begin
                            scl_reg  <= 1'b0;
                            qcnt_reg <= 2'd0;
                            state    <= LOAD;
                        end
                    end

                    LOAD: begin
                        shift_reg   <= byte_next;
                        bit_cnt_reg <= 3'd7;
                        qcnt_reg    <= 2'd0;
                        state       <= TX_BIT;
                    end

                    TX_BIT: begin
                        // scl falls and the new bit appears on the same
                        // quarter; scl is high for quarters 2 and 3.
                        case (qcnt_reg)
                            2'd0: begin
                                scl_reg     <= 1'b0;
                                sda_low_reg <= ~shift_reg[7];
                            end
                            2'd2: scl_reg <= 1'b1;
                            2'd3: begin
                                if (bit_cnt_reg == 3'd0) begin
                                    state <= ACK_RELEASE;
                                end else begin
                                    bit_cnt_reg <= bit_cnt_reg - 3'd1;
                                    shift_reg   <= {shift_reg[6:0], 1'b0};
                                end
                            end
                            default: ;
                        endcase
                    end

                    ACK_RELEASE: begin
                        scl_reg     <= 1'b0;
                        sda_low_reg <= 1'b0;
                        if (qcnt_reg == 2'd1) begin
                            qcnt_reg <= 2'd0;
                            state    <= ACK_SAMPLE;
                        end
                    end

                    ACK_SAMPLE: begin
                        case (qcnt_reg)
                            2'd0: scl_reg <= 1'b1;
                            2'd1: begin
`ifdef I2C_NACK_RETRY_EN
                                // scl has been high for a full quarter here
                                nack_reg <= sda;
`endif
                            end
                            default: begin
                                scl_reg  <= 1'b0;
                                qcnt_reg <= 2'd0;
                                if (frame_end) begin
                                    state <= STOP;
                                end else begin
                                    byte_idx_reg <= byte_idx_reg + 2'd1;
                                    state        <= LOAD;
                                end
                            end
                        endcase
                    end

                    STOP: begin
                        case (qcnt_reg)
                            2'd0: begin
                                scl_reg     <= 1'b0;
                                sda_low_reg <= 1'b1;
                            end
                            2'd1: scl_reg <= 1'b1;
                            default: begin
                                // sda rises while scl is high
                                sda_low_reg <= 1'b0;
                                qcnt_reg    <= 2'd0;
                                state       <= NEXT;
                            end
                        endcase
                    end

                    NEXT: begin
                        if (qcnt_reg == 2'd3) begin
                            if (resend) begin
`ifdef I2C_NACK_RETRY_EN
                                retry_reg <= retry_reg + 2'd1;
`endif
                                state <= START;
                            end else begin
`ifdef I2C_NACK_RETRY_EN
                                retry_reg <= '0;
`endif
                                word_idx_reg <= word_idx_reg + IW'(1);
                                if (last_word) begin
                                    done_reg <= 1'b1;
                                    state    <= DONE;
                                end else begin
                                    state <= START;
                                end
                            end
                        end
                    end

                    DONE: begin
                        scl_reg     <= 1'b1;
                        sda_low_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign scl  = scl_reg;
    assign sda  = sda_low_reg ? 1'b0 : 1'bz;
    assign done = done_reg;

endmodule

// File: tb/tb_wm_codec_i2c_init.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wm_codec_i2c_init
//
// Bench for wm_codec_i2c_init, run with a small divider (QDIV = 4, so one
// SCL bit is 16 system clocks). A passive bus monitor decodes START/STOP,
// captures every byte, measures SCL pulse timing and flags illegal sda
// edges. A slave model acknowledges during the acknowledge slot and can be
// told to NACK the first attempt of word 3.
// -----------------------------------------------------------------------------
module tb_wm_codec_i2c_init;

    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl;
    logic done;
    wire  sda;

    pullup (sda);

    logic       slave_pull;
    logic       nack_on;
    logic [3:0] st;

    assign sda = slave_pull ? 1'b0 : 1'bz;

    wm_codec_i2c_init #(
        .CLK_FREQ (1_600_000),
        .I2C_FREQ (100_000),
        .DEV_ADDR (8'h34),
        .NUM_REGS (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .done  (done)
    );

    always #10 clk = ~clk;

    assign st = dut.state;

    // ---------------- bus monitor state (written only by the monitor) -------
    int         starts, stops, short_frames, viol, period_bad, high_bad;
    int         bit_idx, ncyc, last_rise;
    logic       in_frame, pulse_open, done_early;
    logic [7:0] sr;
    logic [7:0] cap_q [$];
    logic       scl_q, sda_q;
    logic       mon_clear;

    // Slave acknowledges once scl is low in the release slot and through the
    // sample slot; the first attempt of frame index 3 (4th START) can be NACKed.
    assign slave_pull = !(nack_on && starts == 4) &&
                        (((st == 4'd4) && !scl) || (st == 4'd5));

    initial begin : monitor
        int k;
        scl_q = 1'b1;
        sda_q = 1'b1;
        forever begin
            @(negedge clk);
            ncyc++;
            if (mon_clear) begin
                starts = 0; stops = 0; short_frames = 0; viol = 0;
                period_bad = 0; high_bad = 0; bit_idx = 0; last_rise = 0;
                in_frame = 1'b0; pulse_open = 1'b0; done_early = 1'b0;
                sr = 8'h00;
                cap_q.delete();
            end else begin
                if (scl_q && scl && sda_q && !sda) begin
                    if (in_frame) viol++;
                    else begin
                        in_frame = 1'b1;
                        starts++;
                        bit_idx = 0;
                    end
                end else if (scl_q && scl && !sda_q && sda) begin
                    if (in_frame) begin
                        in_frame = 1'b0;
                        stops++;
                        if (bit_idx != 27) short_frames++;
                        if (done) done_early = 1'b1;
                    end else viol++;
                end
                if (!scl_q && scl && in_frame && bit_idx < 27) begin
                    k = bit_idx % 9;
                    if (k >= 1 && (ncyc - last_rise) != 16) period_bad++;
                    last_rise  = ncyc;
                    pulse_open = 1'b1;
                    if (k < 8) sr = {sr[6:0], sda};
                    if (k == 7) cap_q.push_back(sr);
                    bit_idx++;
                end
                if (scl_q && !scl && pulse_open) begin
                    if ((ncyc - last_rise) != 8) high_bad++;
                    pulse_open = 1'b0;
                end
            end
            scl_q = scl;
            sda_q = sda;
        end
    end

    // ---------------- checking ----------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t        vecs [30];
    logic [15:0] words [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    function automatic logic [31:0] cap_at(input int i);
        if (i >= 0 && i < cap_q.size()) return {24'h0, cap_q[i]};
        return 32'hDEAD;
    endfunction

    task automatic wait_done();
        int n = 0;
        while (!done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        mon_clear = 1'b1;
        nack_on   = 1'b0;
        reset     = 1'b0;

        words = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                  16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201};
        for (int f = 0; f < 10; f++) begin
            vecs[3*f]     = '{3*f,     8'h34};
            vecs[3*f + 1] = '{3*f + 1, words[f][15:8]};
            vecs[3*f + 2] = '{3*f + 2, words[f][7:0]};
        end

        // ---- reset state ----
        #200;
        check("rst_scl",   32'(scl),  32'd1);
        check("rst_sda",   32'(sda),  32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_state", 32'(st),   32'd0);

        // ---- run A: full table, every byte acknowledged ----
        @(negedge clk); #2; reset = 1'b1;
        @(negedge clk); #2; mon_clear = 1'b0;
        wait_done();
        check("A_done",        32'(done),         32'd1);
        check("A_state",       32'(st),           32'd8);
        check("A_starts",      32'(starts),       32'd10);
        check("A_stops",       32'(stops),        32'd10);
        check("A_short",       32'(short_frames), 32'd0);
        check("A_sda_viol",    32'(viol),         32'd0);
        check("A_period_bad",  32'(period_bad),   32'd0);
        check("A_high_bad",    32'(high_bad),     32'd0);
        check("A_done_early",  32'(done_early),   32'd0);
        check("A_byte_count",  32'(cap_q.size()), 32'd30);
        for (int i = 0; i < 30; i++) begin
            check($sformatf("A_byte%0d", i), cap_at(vecs[i].idx), 32'(vecs[i].exp));
        end

        // ---- run B: restart, abort with an asynchronous reset in frame 5 ----
        @(negedge clk); #2; reset = 1'b0; mon_clear = 1'b1;
        repeat (3) @(negedge clk);
        #2; reset = 1'b1;
        @(negedge clk); #2; mon_clear = 1'b0;
        n = 0;
        while (!(starts == 5 && bit_idx >= 10 && !scl && !sda) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("B_in_frame5", 32'(starts), 32'd5);
        #3; reset = 1'b0;
        #1;
        check("B_async_scl",   32'(scl),  32'd1);
        check("B_async_sda",   32'(sda),  32'd1);
        check("B_async_done",  32'(done), 32'd0);
        check("B_async_state", 32'(st),   32'd0);
        mon_clear = 1'b1;
        nack_on   = 1'b1;

        // ---- run C: restart from word 0, slave NACKs first try of word 3 ----
        repeat (2) @(negedge clk);
        #2; reset = 1'b1;
        @(negedge clk); #2; mon_clear = 1'b0;
        wait_done();
        check("C_done",     32'(done), 32'd1);
        check("C_first0",   cap_at(0), 32'h34);
        check("C_first1",   cap_at(1), 32'h1E);
        check("C_first2",   cap_at(2), 32'h00);
        check("C_last0",    cap_at(cap_q.size() - 3), 32'h34);
        check("C_last1",    cap_at(cap_q.size() - 2), 32'h12);
        check("C_last2",    cap_at(cap_q.size() - 1), 32'h01);
        check("C_sda_viol", 32'(viol), 32'd0);
`ifdef I2C_NACK_RETRY_EN
        check("C_starts",     32'(starts),       32'd11);
        check("C_stops",      32'(stops),        32'd11);
        check("C_short",      32'(short_frames), 32'd1);
        check("C_byte_count", 32'(cap_q.size()), 32'd31);
        check("C_resend_adr", cap_at(10),        32'h34);
        check("C_resend_hi",  cap_at(11),        32'h04);
`else
        check("C_starts",     32'(starts),       32'd10);
        check("C_stops",      32'(stops),        32'd10);
        check("C_short",      32'(short_frames), 32'd0);
        check("C_byte_count", 32'(cap_q.size()), 32'd30);
        check("C_word3_hi",   cap_at(10),        32'h04);
        check("C_word4_hi",   cap_at(13),        32'h06);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wm_codec_i2c_init.md
Name: wm_codec_i2c_init

Overview:
- Power-up configuration master for a WM8731-class audio codec.
- After reset it writes a fixed table of 16-bit control words over a write-only I2C bus, then raises `done`.
- Sits beside the codec datapath; downstream audio blocks wait for `done` before streaming.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- I2C_FREQ, 100_000: SCL frequency in Hz.
  - Quarter-period divider QDIV = CLK_FREQ/(4*I2C_FREQ), default 125.
- DEV_ADDR, 8'h34: 7-bit codec address plus R/W=0, sent as the first byte.
- NUM_REGS, 10: number of entries in the configuration table.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- scl  output  1  I2C clock, driven push-pull; idles high.
- sda  inout  1  I2C data, open-drain.
  - Drives 0, otherwise releases to 'z'.
  - Input value is sampled from the pad.
- done  output  1  high once the whole table has been written.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; scl=1; sda released; done=0; word index=0; bit counter and divider cleared.
- Quarter tick: divider counts 0..QDIV-1 and produces a 1-cycle tick. All bus activity advances only on ticks.
- Configuration table, word = {7-bit reg addr, 9-bit data}, sent in this order:
  - 0x1E00 (reset codec)
  - 0x0017 and 0x0217 (L/R line in)
  - 0x0479 and 0x0679 (L/R headphone)
  - 0x0812 (DAC select)
  - 0x0A00
  - 0x0C00 (power on)
  - 0x0E42 (master, I2S 16-bit)
  - 0x1201 (active)
- 4-bit `state` register. Encoding is fixed, because benches probe it hierarchically:
  - 0 IDLE, 1 START, 2 LOAD, 3 TX_BIT, 4 ACK_RELEASE, 5 ACK_SAMPLE, 6 STOP, 7 NEXT, 8 DONE.
- IDLE: scl=1, sda released. After 4 ticks go to START.
- START:
  - Tick 1: sda=0 while scl=1.
  - Tick 2: scl=0, then go to LOAD.
- LOAD: select the next byte (DEV_ADDR, word[15:8], word[7:0]); bit counter=7; go to TX_BIT.
- TX_BIT: each bit, MSB first, takes 4 ticks:
  - q0: scl=0, set sda.
  - q1: hold.
  - q2: scl=1.
  - q3: hold, then scl returns low.
  - After bit 0 go to ACK_RELEASE.
- ACK_RELEASE: scl=0 and sda released for 2 ticks.
- ACK_SAMPLE:
  - scl=1 for 2 ticks; sample sda on the first high tick (0=ACK).
  - Then scl=0.
  - If bytes remain in the frame, go to LOAD; otherwise go to STOP.
- STOP: sda=0 with scl low, scl=1, then release sda (sda rises while scl high). Each step takes 1 tick.
- NEXT:
  - 4-tick bus-free gap.
  - Increment the word index.
  - If index==NUM_REGS go to DONE, else go to START.
- DONE: scl=1, sda released, done=1. Stays here until reset.
- Frame = START + 3 bytes, each followed by ACK + STOP: 27 clocked bits, QDIV*4 cycles per bit.
- NACK handling depends on the optional feature.
- Reset mid-frame aborts immediately; the table restarts from word 0 after reset is released.
- scl and sda change only on ticks; sda never changes while scl is high, except for START/STOP.

Optional Feature:
- Macro I2C_NACK_RETRY_EN.
- Defined:
  - A NACK in ACK_SAMPLE ends the frame (STOP, gap) and resends the same word.
  - Up to 3 retries, then the word is skipped.
  - `done` still asserts at the end.
- Undefined: the ACK value is sampled but ignored, and every frame proceeds normally.

Test Plan:
- Reset held low 200 ns -> scl=1, sda=z (pulled high), done=0, state=0.
- Release reset, slave ACKs in states 4/5:
  - Exactly 10 START/STOP pairs.
  - First frame bytes 0x34, 0x1E, 0x00; last frame bytes 0x34, 0x12, 0x01.
  - done rises after the final STOP.
- SCL timing: measured period = 4*QDIV*20 ns = 10 us; high/low each 5 us.
- SDA stability: no sda edge while scl high except START (falling) and STOP (rising).
- Assert reset mid-frame 5 -> immediately scl=1, sda released, done=0; after release the sequence restarts with word 0x1E00.
- With I2C_NACK_RETRY_EN, slave NACKs the first attempt of word 3 -> the word is resent once more, 11 frames total, done=1; without the macro, 10 frames total.
